// File: rtl/multdiv_unit_if.sv
// Operand, control and result signals shared by the execute stage and the multiply/divide unit.
interface multdiv_unit_if #(parameter int WIDTH = 32);
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    modport master (
        output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        input  data_result, data_exception, data_resultRDY, busy
    );
    modport slave (
        input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        output data_result, data_exception, data_resultRDY, busy
    );
endinterface

// File: rtl/multdiv_unit.sv
// Multi-cycle signed multiply (radix-2 shift-add) / divide (restoring) unit.
// Works on operand magnitudes and applies the result sign in a final fix-up cycle.
module multdiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic           clock,
    input  logic           reset,
    multdiv_unit_if.slave  bus
);
    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_is_mul;
    logic               r_neg;
    logic               r_dz;
    logic [WIDTH-1:0]   r_mc;      // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0] r_prod;    // {accumulator, remaining multiplier bits}
    logic [WIDTH:0]     r_rem;
    logic [WIDTH-1:0]   r_quo;     // dividend bits shift out as quotient bits shift in
    logic [WIDTH-1:0]   r_result;
    logic               r_exc;
    logic               r_rdy;
    logic               r_busy;

    logic               w_accept;
    logic [WIDTH-1:0]   w_amag;
    logic [WIDTH-1:0]   w_bmag;
    logic [WIDTH:0]     w_msum;
    logic [WIDTH:0]     w_rs;
    logic [WIDTH+1:0]   w_trial;
    logic [2*WIDTH-1:0] w_pfix;
    logic [WIDTH-1:0]   w_qfix;

    assign w_accept = (r_state == S_IDLE || r_state == S_DONE) && (bus.ctrl_MULT || bus.ctrl_DIV);
    assign w_amag   = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
    assign w_bmag   = bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;

    assign w_msum   = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_mc} : '0);
    assign w_rs     = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
    assign w_trial  = {1'b0, w_rs} - {2'b00, r_mc};

    assign w_pfix   = r_neg ? -r_prod : r_prod;
    assign w_qfix   = r_neg ? -r_quo : r_quo;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_is_mul <= 1'b0;
            r_neg    <= 1'b0;
            r_dz     <= 1'b0;
            r_mc     <= '0;
            r_prod   <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_result <= '0;
            r_exc    <= 1'b0;
            r_rdy    <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_rdy <= 1'b0;
            if (w_accept) begin
                r_is_mul <= bus.ctrl_MULT;
                r_neg    <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
                r_dz     <= !bus.ctrl_MULT && (bus.data_operandB == '0);
                r_cnt    <= '0;
                r_busy   <= 1'b1;
                r_rem    <= '0;
                r_quo    <= w_amag;
                r_mc     <= bus.ctrl_MULT ? w_amag : w_bmag;
                r_prod   <= {{WIDTH{1'b0}}, w_bmag};
                r_state  <= bus.ctrl_MULT ? S_MUL : S_DIV;
            end else begin
                case (r_state)
                    S_MUL: begin
                        if (r_cnt == CNT_W'(WIDTH)) begin
                            r_state <= S_FIX;
                        end else begin
                            r_prod <= {w_msum, r_prod[WIDTH-1:1]};
                            r_cnt  <= r_cnt + CNT_W'(1);
                        end
                    end
                    S_DIV: begin
                        if (r_dz) begin
                            r_result <= '0;
                            r_exc    <= 1'b1;
                            r_rdy    <= 1'b1;
                            r_busy   <= 1'b0;
                            r_state  <= S_DONE;
                        end else if (r_cnt == CNT_W'(WIDTH)) begin
                            r_state <= S_FIX;
                        end else begin
                            r_rem <= w_trial[WIDTH+1] ? w_rs : w_trial[WIDTH:0];
                            r_quo <= {r_quo[WIDTH-2:0], ~w_trial[WIDTH+1]};
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    S_FIX: begin
                        if (r_is_mul) begin
                            r_result <= w_pfix[WIDTH-1:0];
                            r_exc    <= w_pfix[2*WIDTH-1:WIDTH] != {WIDTH{w_pfix[WIDTH-1]}};
                        end else begin
                            // A positive quotient with the top bit set only arises from MIN / -1.
                            r_result <= (!r_neg && r_quo[WIDTH-1]) ? '0 : w_qfix;
                            r_exc    <= !r_neg && r_quo[WIDTH-1];
                        end
                        r_rdy   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end
                    S_DONE:  r_state <= S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.data_result    = r_result;
    assign bus.data_exception = r_exc;
    assign bus.data_resultRDY = r_rdy;
    assign bus.busy           = r_busy;
endmodule

// File: tb/tb_multdiv_unit.sv
// Randomized self-checking bench for multdiv_unit against a plain-arithmetic signed model.
module tb_multdiv_unit;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    multdiv_unit_if #(.WIDTH(32)) bus ();
    multdiv_unit #(.WIDTH(32), .CNT_W(6)) dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic mul, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] res, output logic exc, output int lat);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint p;
        lat = 34;
        if (mul) begin
            p   = sa * sb;
            res = p[31:0];
            exc = (p > 64'sd2147483647) || (p < -64'sd2147483648);
        end else if (b == 32'd0) begin
            res = 32'd0; exc = 1'b1; lat = 1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            res = 32'd0; exc = 1'b1;
        end else begin
            p   = sa / sb;
            res = p[31:0];
            exc = 1'b0;
        end
    endfunction

    // Issue one start from the current cycle; optionally pulse a stray start at cycle inj.
    task automatic run(input string tag, input logic m, input logic d, input logic [31:0] a,
                       input logic [31:0] b, input int inj, input logic inj_mul);
        logic [31:0] er;
        logic        ee;
        int          el;
        int          k;
        bit          got;
        model(m, a, b, er, ee, el);
        bus.ctrl_MULT = m; bus.ctrl_DIV = d;
        bus.data_operandA = a; bus.data_operandB = b;
        @(posedge clock); #1;
        bus.ctrl_MULT = 1'b0; bus.ctrl_DIV = 1'b0;
        bus.data_operandA = $urandom; bus.data_operandB = $urandom;
        if (el > 1) chk({tag, "_busy"}, 64'(bus.busy), 64'd1);
        k = 0; got = 0;
        while (!got && k < 60) begin
            if (k == inj) begin
                bus.ctrl_MULT = inj_mul; bus.ctrl_DIV = ~inj_mul;
            end
            @(posedge clock); #1;
            bus.ctrl_MULT = 1'b0; bus.ctrl_DIV = 1'b0;
            k++;
            if (bus.data_resultRDY) got = 1;
        end
        chk({tag, "_lat"}, 64'(k), 64'(el));
        chk({tag, "_res"}, 64'(bus.data_result), 64'(er));
        chk({tag, "_exc"}, 64'(bus.data_exception), 64'(ee));
        chk({tag, "_idle"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        bit   seen;
        bus.ctrl_MULT = 1'b0; bus.ctrl_DIV = 1'b0;
        bus.data_operandA = '0; bus.data_operandB = '0;
        #12;
        chk("rst_res", 64'(bus.data_result), 64'd0);
        chk("rst_flags", {61'd0, bus.data_exception, bus.data_resultRDY, bus.busy}, 64'd0);
        reset = 1'b0;
        @(posedge clock); #1;

        run("mul7m3",  1, 0, 32'd7, -32'sd3, -1, 0);
        run("mulovf",  1, 0, 32'h0001_0000, 32'h0001_0000, -1, 0);
        run("mulmax",  1, 0, 32'h7FFF_FFFF, 32'd1, -1, 0);
        run("divm7",   0, 1, -32'sd7, 32'd2, -1, 0);
        run("div100",  0, 1, 32'd100, 32'd7, -1, 0);
        run("divz",    0, 1, 32'd5, 32'd0, -1, 0);
        run("divmin",  0, 1, 32'h8000_0000, 32'hFFFF_FFFF, -1, 0);
        run("divmin1", 0, 1, 32'h8000_0000, 32'd1, -1, 0);
        run("mulmin",  1, 0, 32'h8000_0000, 32'hFFFF_FFFF, -1, 0);
        run("both",    1, 1, 32'd6, 32'd5, -1, 0);
        run("middiv",  1, 0, 32'd1234, -32'sd99, 10, 0);
        run("fixstrt", 1, 0, 32'd9, 32'd9, 33, 1);
        @(posedge clock); #1;
        chk("fix_ignored", 64'(bus.busy), 64'd0);

        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 3 == 0) begin
                ra = 32'($signed(16'($urandom)));
                rb = 32'($signed(8'($urandom)));
            end
            run(i % 2 ? "rdiv" : "rmul", i % 2 == 0, i % 2 == 1, ra, rb, -1, 0);
        end

        // Reset mid-multiply: outputs clear without waiting for a clock edge.
        bus.ctrl_MULT = 1'b1; bus.data_operandA = 32'd50; bus.data_operandB = 32'd60;
        @(posedge clock); #1;
        bus.ctrl_MULT = 1'b0;
        repeat (10) @(posedge clock);
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", 64'(bus.busy), 64'd0);
        chk("arst_res", 64'(bus.data_result), 64'd0);
        chk("arst_exc", 64'(bus.data_exception), 64'd0);
        @(posedge clock); #1 reset = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clock); #1;
            if (bus.data_resultRDY) seen = 1;
        end
        chk("arst_nordy", 64'(seen), 64'd0);
        run("mul3x4", 1, 0, 32'd3, 32'd4, -1, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
